// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    localparam logic [31:0] RAM_BASE_DEFAULT  = 32'h0000_1000;
    localparam int unsigned RAM_WORDS_DEFAULT = 1024;

    // Word-aligned and inside [base, base + 4*words); 33-bit compare so the
    // upper bound never wraps around the 32-bit address space.
    function automatic logic addr_valid(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
        logic [32:0] a_ext;
        logic [32:0] lo;
        logic [32:0] hi;
        a_ext = {1'b0, addr};
        lo    = {1'b0, base};
        hi    = lo + ({1'b0, words[31:0]} << 2);
        return (addr[1:0] == 2'b00) && (a_ext >= lo) && (a_ext < hi);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection: round-robin on ties, or fixed priority to port 0.
module rr_arb2
    import ram_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic     valid0,
    input  logic     valid1,
    input  port_id_t last_grant,
    output logic     gnt0,
    output logic     gnt1,
    output port_id_t gnt_id
);

    // Pick at most one requester; ties go to the port not served last (or port 0).
    always_comb begin
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        gnt_id = PORT0;
        case ({valid1, valid0})
            2'b01: begin
                gnt0 = 1'b1;
            end
            2'b10: begin
                gnt1   = 1'b1;
                gnt_id = PORT1;
            end
            2'b11: begin
                if (RR_EN && (last_grant == PORT0)) begin
                    gnt1   = 1'b1;
                    gnt_id = PORT1;
                end else begin
                    gnt0 = 1'b1;
                end
            end
            default: begin
                gnt0   = 1'b0;
                gnt1   = 1'b0;
                gnt_id = PORT0;
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port request/response front end sharing one single-cycle RAM.
// Each transaction takes IDLE -> ACCESS -> RESP, response two cycles after accept.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = RAM_BASE_DEFAULT,
    parameter int unsigned RAM_WORDS = RAM_WORDS_DEFAULT,
    parameter bit          RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req_valid,
    output logic        m0_req_ready,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_rsp_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_rsp_err,
    input  logic        m1_req_valid,
    output logic        m1_req_ready,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_rsp_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_rsp_err,
    output logic        MemWrite,
    output logic [31:0] A,
    output logic [31:0] WriteData,
    input  logic [31:0] ReadData,
    output logic        busy
);

    arb_state_t  state_r, next_state_s;
    port_id_t    last_grant_r, lat_port_r, gnt_id_s;
    logic        gnt0_s, gnt1_s, accept_s;
    logic        sel_we_s, sel_ok_s;
    logic [31:0] sel_addr_s, sel_wdata_s;
    logic        lat_we_r, lat_ok_r;
    logic        mem_write_r, busy_r;
    logic [31:0] a_r, write_data_r;
    logic        m0_rsp_valid_r, m0_rsp_err_r, m1_rsp_valid_r, m1_rsp_err_r;
    logic [31:0] m0_rdata_r, m1_rdata_r;

    rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
        .valid0     (m0_req_valid),
        .valid1     (m1_req_valid),
        .last_grant (last_grant_r),
        .gnt0       (gnt0_s),
        .gnt1       (gnt1_s),
        .gnt_id     (gnt_id_s)
    );

    // Next state and ready handshake; grants are only offered while idle.
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        case (state_r)
            IDLE: begin
                m0_req_ready = gnt0_s;
                m1_req_ready = gnt1_s;
                if (gnt0_s || gnt1_s) begin
                    accept_s     = 1'b1;
                    next_state_s = ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:  next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Route the granted port's request fields to the capture registers.
    always_comb begin
        sel_we_s    = m0_we;
        sel_addr_s  = m0_addr;
        sel_wdata_s = m0_wdata;
        if (gnt_id_s == PORT1) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
        sel_ok_s = addr_valid(sel_addr_s, RAM_BASE, RAM_WORDS);
    end

    // State register, busy flag and round-robin history (moves on accept only).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= PORT1;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s != IDLE);
            if (accept_s) begin
                last_grant_r <= gnt_id_s;
            end
        end
    end

    // Capture the accepted request; RAM-side outputs come straight from these
    // registers so MemWrite is high only for the ACCESS cycle of a valid write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_write_r  <= 1'b0;
            a_r          <= 32'h0;
            write_data_r <= 32'h0;
            lat_we_r     <= 1'b0;
            lat_ok_r     <= 1'b0;
            lat_port_r   <= PORT0;
        end else if (accept_s) begin
            mem_write_r  <= sel_we_s && sel_ok_s;
            a_r          <= sel_addr_s;
            write_data_r <= sel_wdata_s;
            lat_we_r     <= sel_we_s;
            lat_ok_r     <= sel_ok_s;
            lat_port_r   <= gnt_id_s;
        end else begin
            mem_write_r <= 1'b0;
        end
    end

    // Sample the RAM at the end of ACCESS and raise a one-cycle response on the originating port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0_rsp_valid_r <= 1'b0;
            m0_rsp_err_r   <= 1'b0;
            m0_rdata_r     <= 32'h0;
            m1_rsp_valid_r <= 1'b0;
            m1_rsp_err_r   <= 1'b0;
            m1_rdata_r     <= 32'h0;
        end else begin
            m0_rsp_valid_r <= 1'b0;
            m1_rsp_valid_r <= 1'b0;
            if (state_r == ACCESS) begin
                if (lat_port_r == PORT1) begin
                    m1_rsp_valid_r <= 1'b1;
                    m1_rsp_err_r   <= !lat_ok_r;
                    m1_rdata_r     <= (lat_ok_r && !lat_we_r) ? ReadData : 32'h0;
                end else begin
                    m0_rsp_valid_r <= 1'b1;
                    m0_rsp_err_r   <= !lat_ok_r;
                    m0_rdata_r     <= (lat_ok_r && !lat_we_r) ? ReadData : 32'h0;
                end
            end
        end
    end

    assign MemWrite     = mem_write_r;
    assign A            = a_r;
    assign WriteData    = write_data_r;
    assign busy         = busy_r;
    assign m0_rsp_valid = m0_rsp_valid_r;
    assign m0_rsp_err   = m0_rsp_err_r;
    assign m0_rdata     = m0_rdata_r;
    assign m1_rsp_valid = m1_rsp_valid_r;
    assign m1_rsp_err   = m1_rsp_err_r;
    assign m1_rdata     = m1_rdata_r;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a round-robin instance on a RAM model plus a
// fixed-priority instance used for the tie-breaking sequence.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m0_req_valid, m0_we, m1_req_valid, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_req_ready, m0_rsp_valid, m0_rsp_err;
    logic        m1_req_ready, m1_rsp_valid, m1_rsp_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemWrite, busy;
    logic [31:0] A, WriteData, ReadData;

    logic        f0_req_valid, f1_req_valid;
    logic [31:0] f0_addr, f1_addr;
    logic        f0_req_ready, f0_rsp_valid, f0_rsp_err;
    logic        f1_req_ready, f1_rsp_valid, f1_rsp_err;
    logic [31:0] f0_rdata, f1_rdata;
    logic        f_mem_write, f_busy;
    logic [31:0] f_a, f_write_data;
    logic [31:0] f_read_data;

    logic [31:0] mem [0:1023];
    int          bad_mw = 0;
    int          checks = 0;
    int          fails  = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.RAM_BASE(32'h1000), .RAM_WORDS(1024), .RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_we(m0_we),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid),
        .m0_rdata(m0_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_we(m1_we),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid),
        .m1_rdata(m1_rdata), .m1_rsp_err(m1_rsp_err),
        .MemWrite(MemWrite), .A(A), .WriteData(WriteData), .ReadData(ReadData),
        .busy(busy)
    );

    ram_arbiter #(.RAM_BASE(32'h1000), .RAM_WORDS(1024), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req_valid(f0_req_valid), .m0_req_ready(f0_req_ready), .m0_we(1'b0),
        .m0_addr(f0_addr), .m0_wdata(32'h0), .m0_rsp_valid(f0_rsp_valid),
        .m0_rdata(f0_rdata), .m0_rsp_err(f0_rsp_err),
        .m1_req_valid(f1_req_valid), .m1_req_ready(f1_req_ready), .m1_we(1'b0),
        .m1_addr(f1_addr), .m1_wdata(32'h0), .m1_rsp_valid(f1_rsp_valid),
        .m1_rdata(f1_rdata), .m1_rsp_err(f1_rsp_err),
        .MemWrite(f_mem_write), .A(f_a), .WriteData(f_write_data), .ReadData(f_read_data),
        .busy(f_busy)
    );

    assign f_read_data = 32'h0;

    function automatic logic in_ram(input logic [31:0] a);
        return (a >= 32'h1000) && (a < 32'h2000);
    endfunction

    // RAM model: combinational read, write on rising edge; out-of-range reads return a marker.
    always_comb ReadData = in_ram(A) ? mem[A[11:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (MemWrite && in_ram(A)) mem[A[11:2]] <= WriteData;
        if (MemWrite && (!in_ram(A) || (A[1:0] != 2'b00))) bad_mw <= bad_mw + 1;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 1) begin
            m1_req_valid = v; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req_valid = v; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    // One complete transaction on one port, checking every cycle of it.
    task automatic txn(input string tag, input int p, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic exp_mw, input logic exp_err, input logic [31:0] exp_rdata);
        drive(p, 1'b1, we, addr, wdata);
        #1;
        check1({tag, " ready"}, (p == 1) ? m1_req_ready : m0_req_ready, 1'b1);
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check1({tag, " memwrite"}, MemWrite, exp_mw);
        check1({tag, " busy access"}, busy, 1'b1);
        check32({tag, " addr out"}, A, addr);
        if (exp_mw) check32({tag, " wdata out"}, WriteData, wdata);
        check1({tag, " no early rsp"}, (p == 1) ? m1_rsp_valid : m0_rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check1({tag, " rsp_valid"}, (p == 1) ? m1_rsp_valid : m0_rsp_valid, 1'b1);
        check1({tag, " other rsp quiet"}, (p == 1) ? m0_rsp_valid : m1_rsp_valid, 1'b0);
        check1({tag, " rsp_err"}, (p == 1) ? m1_rsp_err : m0_rsp_err, exp_err);
        check32({tag, " rdata"}, (p == 1) ? m1_rdata : m0_rdata, exp_rdata);
        check1({tag, " memwrite resp"}, MemWrite, 1'b0);
        @(negedge clk);
        #1;
        check1({tag, " rsp one cycle"}, (p == 1) ? m1_rsp_valid : m0_rsp_valid, 1'b0);
        check1({tag, " busy idle"}, busy, 1'b0);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        f0_req_valid = 1'b0; f1_req_valid = 1'b0;
        f0_addr = 32'h1000;  f1_addr = 32'h1004;

        // Reset values while rst is held low.
        @(negedge clk);
        #1;
        check1("rst memwrite", MemWrite, 1'b0);
        check32("rst A", A, 32'h0);
        check32("rst writedata", WriteData, 32'h0);
        check1("rst busy", busy, 1'b0);
        check1("rst m0 rsp_valid", m0_rsp_valid, 1'b0);
        check1("rst m1 rsp_err", m1_rsp_err, 1'b0);
        check32("rst m0 rdata", m0_rdata, 32'h0);
        check32("rst m1 rdata", m1_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Write then read back on port 0.
        txn("wr1000", 0, 1'b1, 32'h1000, 32'h13FF, 1'b1, 1'b0, 32'h0);
        txn("rd1000", 0, 1'b0, 32'h1000, 32'h0, 1'b0, 1'b0, 32'h13FF);

        // Simultaneous requests after reset: port 0 first, port 1 next idle slot.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h1004, 32'h100);
        #1;
        check1("tie m0 ready", m0_req_ready, 1'b1);
        check1("tie m1 waits", m1_req_ready, 1'b0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check1("tie m1 wait access", m1_req_ready, 1'b0);
        check32("tie A m0", A, 32'h1000);
        @(negedge clk);
        #1;
        check1("tie m0 rsp", m0_rsp_valid, 1'b1);
        check32("tie m0 rdata", m0_rdata, 32'h13FF);
        check1("tie m1 wait resp", m1_req_ready, 1'b0);
        @(negedge clk);
        #1;
        check1("tie m1 ready", m1_req_ready, 1'b1);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check1("tie m1 memwrite", MemWrite, 1'b1);
        check32("tie m1 A", A, 32'h1004);
        check32("tie m1 writedata", WriteData, 32'h100);
        @(negedge clk);
        #1;
        check1("tie m1 rsp", m1_rsp_valid, 1'b1);
        check1("tie m1 err", m1_rsp_err, 1'b0);
        @(negedge clk);
        #1;
        txn("rd1004", 1, 1'b0, 32'h1004, 32'h0, 1'b0, 1'b0, 32'h100);

        // Continuous contention: alternating grants vs. always port 0.
        reset_pulse();
        drive(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h1004, 32'h0);
        f0_req_valid = 1'b1; f1_req_valid = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            int w;
            w = 0;
            while (!(m0_req_ready || m1_req_ready) && (w < 6)) begin
                @(negedge clk);
                #1;
                w++;
            end
            check32($sformatf("rr grant %0d", k), {30'h0, m1_req_ready, m0_req_ready},
                    (k % 2 == 1) ? 32'h2 : 32'h1);
            check32($sformatf("fp grant %0d", k), {30'h0, f1_req_ready, f0_req_ready}, 32'h1);
            @(negedge clk);
            #1;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        f0_req_valid = 1'b0; f1_req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check32("rr m1 rdata", m1_rdata, 32'h100);
        check1("fp idle", f_busy, 1'b0);

        // Invalid addresses: below base, misaligned, one past the end.
        txn("err0ffc", 0, 1'b1, 32'h0FFC, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        txn("err1002", 1, 1'b1, 32'h1002, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        txn("err2000w", 0, 1'b1, 32'h2000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0);
        txn("err2000r", 1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b1, 32'h0);
        txn("wr1ffc", 0, 1'b1, 32'h1FFC, 32'h77, 1'b1, 1'b0, 32'h0);
        txn("rd1ffc", 1, 1'b0, 32'h1FFC, 32'h0, 1'b0, 1'b0, 32'h77);
        check32("ram word0 intact", mem[0], 32'h13FF);
        check32("ram word1 intact", mem[1], 32'h100);
        check32("no bad memwrite", bad_mw, 32'h0);

        // Reset in the middle of a write's ACCESS cycle aborts it.
        txn("wr1008", 0, 1'b1, 32'h1008, 32'h5555, 1'b1, 1'b0, 32'h0);
        txn("rd1008", 1, 1'b0, 32'h1008, 32'h0, 1'b0, 1'b0, 32'h5555);
        drive(0, 1'b1, 1'b1, 32'h1008, 32'hABCD);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check1("abort memwrite before", MemWrite, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check1("abort memwrite drop", MemWrite, 1'b0);
        check1("abort busy", busy, 1'b0);
        check32("abort m1 rdata cleared", m1_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check32($sformatf("abort quiet %0d", c), {29'h0, busy, m1_rsp_valid, m0_rsp_valid}, 32'h0);
            @(negedge clk);
        end
        #1;
        check32("abort ram unchanged", mem[2], 32'h5555);
        txn("rd1008 post", 0, 1'b0, 32'h1008, 32'h0, 1'b0, 1'b0, 32'h5555);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
